// File: rtl/instr_mem_resp_if.sv
// Fetch/instruction-memory bus: read address/response plus the boot-load word stream.
// master = fetch/loader side, slave = memory responder.
interface instr_mem_resp_if;
  logic [31:0] instr_addr_in;
  logic [31:0] instr_dat_out;
  logic        instr_fault;
  logic        imem_busy;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        par_err;

  modport master (
    output instr_addr_in, ld_valid, ld_data, ld_last,
    input  instr_dat_out, instr_fault, imem_busy, ld_ready, par_err
  );

  modport slave (
    input  instr_addr_in, ld_valid, ld_data, ld_last,
    output instr_dat_out, instr_fault, imem_busy, ld_ready, par_err
  );
endinterface

// File: rtl/instr_mem_resp.sv
// Instruction-memory responder: boot-loads the array from a valid/ready word stream,
// then answers fetch addresses with one cycle of latency.
// Optional feature macro: IMEM_PARITY_EN (per-word even parity bit, checked on read).
module instr_mem_resp #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter bit          BOOT_LOAD   = 1'b1
) (
  input logic             clk,
  input logic             rst,
  instr_mem_resp_if.slave bus
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [31:0] Nop      = 32'h0000_0013;
  localparam logic [32:0] OffLimit = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [AW-1:0] LastIdx = AW'(DEPTH_WORDS - 1);
`ifdef IMEM_PARITY_EN
  localparam int unsigned MemW = 33;
`else
  localparam int unsigned MemW = 32;
`endif

  typedef enum logic {StLoad, StRun} state_e;
  localparam state_e ResetState = BOOT_LOAD ? StLoad : StRun;

  state_e          state_q, state_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [MemW-1:0] mem_q [DEPTH_WORDS];
  logic            xfer;
  logic            final_word;
  logic [MemW-1:0] wdata;
  logic [31:0]     off;
  logic            bad;
  logic [AW-1:0]   ridx;
  logic [MemW-1:0] rword;
  logic [31:0]     dat_q;
  logic            fault_q;
  logic            par_q;

  // Load FSM next state: advance wptr per transfer, leave LOAD on last word or full array.
  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    xfer       = (state_q == StLoad) && bus.ld_valid;
    final_word = bus.ld_last || (wptr_q == LastIdx);
    if (xfer) begin
      if (final_word) begin
        state_d = StRun;  // wptr is held so it never wraps
      end else begin
        wptr_d = wptr_q + 1'b1;
      end
    end
  end

  // State and write-pointer registers; reset restarts any load at word 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ResetState;
      wptr_q  <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
    end
  end

`ifdef IMEM_PARITY_EN
  assign wdata = {^bus.ld_data, bus.ld_data};
`else
  assign wdata = bus.ld_data;
`endif

  // Array write port; contents survive reset by design.
  always_ff @(posedge clk) begin
    if (xfer && !rst) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  // Addresses below BASE_ADDR wrap to a huge offset and fall out of range.
  assign off   = bus.instr_addr_in - BASE_ADDR;
  assign bad   = (off[1:0] != 2'b00) || ({1'b0, off} >= OffLimit);
  assign ridx  = off[AW+1:2];
  assign rword = mem_q[ridx];

  // Registered read response; NOP with no fault while loading.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dat_q   <= Nop;
      fault_q <= 1'b0;
      par_q   <= 1'b0;
    end else if (state_q == StLoad) begin
      dat_q   <= Nop;
      fault_q <= 1'b0;
      par_q   <= 1'b0;
    end else if (bad) begin
      dat_q   <= Nop;
      fault_q <= 1'b1;
      par_q   <= 1'b0;
    end else begin
      dat_q   <= rword[31:0];
`ifdef IMEM_PARITY_EN
      par_q   <= ^rword;
      fault_q <= ^rword;
`else
      par_q   <= 1'b0;
      fault_q <= 1'b0;
`endif
    end
  end

  assign bus.instr_dat_out = dat_q;
  assign bus.instr_fault   = fault_q;
  assign bus.par_err       = par_q;
  assign bus.ld_ready      = (state_q == StLoad);
  assign bus.imem_busy     = (state_q == StLoad);

endmodule
